// File: rtl/video_ram_arbiter_if.sv
// Bus bundle between the video RAM arbiter, its two requesters (Z8 core and
// video fetch unit) and the single-port video RAM.
interface video_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  cpuReq;
  logic                  cpuWe;
  logic [ADDR_WIDTH-1:0] cpuAddr;
  logic [DATA_WIDTH-1:0] cpuWdata;
  logic [DATA_WIDTH-1:0] cpuRdata;
  logic                  cpuAck;
  logic                  cpuWait;
  logic                  videoReq;
  logic [ADDR_WIDTH-1:0] videoAddr;
  logic [DATA_WIDTH-1:0] videoRdata;
  logic                  videoAck;
  logic                  ramEn;
  logic                  ramWe;
  logic [ADDR_WIDTH-1:0] ramAddr;
  logic [DATA_WIDTH-1:0] ramWdata;
  logic [DATA_WIDTH-1:0] ramRdata;

  modport slave (
    input  cpuReq, cpuWe, cpuAddr, cpuWdata, videoReq, videoAddr, ramRdata,
    output cpuRdata, cpuAck, cpuWait, videoRdata, videoAck,
           ramEn, ramWe, ramAddr, ramWdata
  );

  modport master (
    output cpuReq, cpuWe, cpuAddr, cpuWdata, videoReq, videoAddr, ramRdata,
    input  cpuRdata, cpuAck, cpuWait, videoRdata, videoAck,
           ramEn, ramWe, ramAddr, ramWdata
  );
endinterface

// File: rtl/video_ram_arbiter.sv
// Arbitrates the single-port video RAM between CPU and video fetch: video has
// fixed priority, a saturating starvation counter bounds how long the CPU waits.
module video_ram_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 3
) (
  input  logic               clk,
  input  logic               reset,
  video_ram_arbiter_if.slave bus
);
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic                  grant_video_p1;
  logic [SW-1:0]         starve_q;
  logic                  en_p1, we_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;
  logic                  pick_video, pick_cpu, starved;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == STARVE_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    pick_video = 1'b0;
    pick_cpu   = 1'b0;
    starved    = bus.cpuReq && (starve_q == STARVE_MAX);
    case (state_q)
      IDLE: begin
        if (bus.videoReq && !starved) begin
          pick_video = 1'b1;
          state_d    = ACCESS;
        end else if (bus.cpuReq) begin
          pick_cpu = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: winner latched and RAM command registered; RAM samples it at the end of ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_video_p1 <= 1'b0;
      starve_q       <= '0;
      en_p1          <= 1'b0;
      we_p1          <= 1'b0;
      addr_p1        <= '0;
      wdata_p1       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (pick_cpu || !bus.cpuReq) starve_q <= '0;
        else if (pick_video)         starve_q <= sat_inc(starve_q);
      end
      if (pick_video) begin
        grant_video_p1 <= 1'b1;
        en_p1          <= 1'b1;
        we_p1          <= 1'b0;
        addr_p1        <= bus.videoAddr;
      end else if (pick_cpu) begin
        grant_video_p1 <= 1'b0;
        en_p1          <= 1'b1;
        we_p1          <= bus.cpuWe;
        addr_p1        <= bus.cpuAddr;
        wdata_p1       <= bus.cpuWdata;
      end else if (state_q == ACCESS) begin
        en_p1 <= 1'b0;
        we_p1 <= 1'b0;
      end
    end
  end

  // Stage p2 (DONE): read data arrives from the RAM and the granted side is acked.
  assign bus.cpuAck     = (state_q == DONE) && !grant_video_p1;
  assign bus.videoAck   = (state_q == DONE) &&  grant_video_p1;
  assign bus.cpuRdata   = bus.ramRdata;
  assign bus.videoRdata = bus.ramRdata;
  assign bus.cpuWait    = bus.cpuReq && !bus.cpuAck;
  assign bus.ramEn      = en_p1;
  assign bus.ramWe      = we_p1;
  assign bus.ramAddr    = addr_p1;
  assign bus.ramWdata   = wdata_p1;
endmodule

// File: tb/tb_video_ram_arbiter.sv
// Directed bench for video_ram_arbiter: per-cycle vector table on the default
// instance plus a starvation sequence on a STARVE_LIMIT=2 instance.
module tb_video_ram_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  video_ram_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus ();
  video_ram_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus2 ();

  video_ram_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(rst), .bus(bus.slave));
  video_ram_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .STARVE_LIMIT(2)) dut2 (
    .clk(clk), .reset(rst), .bus(bus2.slave));

  logic [7:0] mem [0:4095];
  logic [7:0] rd1, rd2;

  always @(posedge clk) begin
    if (bus.ramEn === 1'b1) begin
      if (bus.ramWe === 1'b1) mem[bus.ramAddr] <= bus.ramWdata;
      rd1 <= mem[bus.ramAddr];
    end
  end
  assign bus.ramRdata = rd1;

  always @(posedge clk) begin
    if (bus2.ramEn === 1'b1) rd2 <= bus2.ramAddr[7:0];
  end
  assign bus2.ramRdata = rd2;

  typedef struct {
    logic        rst, creq, cwe;
    logic [11:0] caddr;
    logic [7:0]  cwd;
    logic        vreq;
    logic [11:0] vaddr;
    logic        en, we;
    logic [11:0] addr;
    logic [7:0]  wd;
    logic        cack, vack, cwait, chkrd;
    logic [7:0]  rd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic creq, input logic cwe, input logic [11:0] caddr,
                     input logic [7:0] cwd, input logic vreq, input logic [11:0] vaddr,
                     input logic en, input logic we, input logic [11:0] addr, input logic [7:0] wd,
                     input logic cack, input logic vack, input logic cwait,
                     input logic chkrd, input logic [7:0] rd);
    vec_t v;
    v.rst = r; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.vreq = vreq; v.vaddr = vaddr; v.en = en; v.we = we; v.addr = addr; v.wd = wd;
    v.cack = cack; v.vack = vack; v.cwait = cwait; v.chkrd = chkrd; v.rd = rd;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    mem[12'h123] = 8'h5A;

    //   rst cr we caddr   cwd    vr vaddr   en we addr    wd     ca va cw ck rd
    // reset release, idle
    add(0, 0, 0, 12'h000, 8'h00, 0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 8'h00);
    add(0, 0, 0, 12'h000, 8'h00, 0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 8'h00);
    // CPU read 0x123
    add(0, 1, 0, 12'h123, 8'h00, 0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 1, 0, 8'h00);
    add(0, 1, 0, 12'h123, 8'h00, 0, 12'h000, 1, 0, 12'h123, 8'h00, 0, 0, 1, 0, 8'h00);
    add(0, 1, 0, 12'h123, 8'h00, 0, 12'h000, 0, 0, 12'h123, 8'h00, 1, 0, 0, 1, 8'h5A);
    add(0, 0, 0, 12'h000, 8'h00, 0, 12'h000, 0, 0, 12'h123, 8'h00, 0, 0, 0, 0, 8'h00);
    // CPU write 0xA5 -> 0x0FF, then video reads it back
    add(0, 1, 1, 12'h0FF, 8'hA5, 0, 12'h000, 0, 0, 12'h123, 8'h00, 0, 0, 1, 0, 8'h00);
    add(0, 1, 1, 12'h0FF, 8'hA5, 0, 12'h000, 1, 1, 12'h0FF, 8'hA5, 0, 0, 1, 0, 8'h00);
    add(0, 1, 1, 12'h0FF, 8'hA5, 0, 12'h000, 0, 0, 12'h0FF, 8'hA5, 1, 0, 0, 0, 8'h00);
    add(0, 0, 0, 12'h000, 8'h00, 1, 12'h0FF, 0, 0, 12'h0FF, 8'hA5, 0, 0, 0, 0, 8'h00);
    add(0, 0, 0, 12'h000, 8'h00, 1, 12'h0FF, 1, 0, 12'h0FF, 8'hA5, 0, 0, 0, 0, 8'h00);
    add(0, 0, 0, 12'h000, 8'h00, 1, 12'h0FF, 0, 0, 12'h0FF, 8'hA5, 0, 1, 0, 1, 8'hA5);
    add(0, 0, 0, 12'h000, 8'h00, 0, 12'h000, 0, 0, 12'h0FF, 8'hA5, 0, 0, 0, 0, 8'h00);
    // simultaneous requests: video first, CPU after
    add(0, 1, 0, 12'h123, 8'h00, 1, 12'h0FF, 0, 0, 12'h0FF, 8'hA5, 0, 0, 1, 0, 8'h00);
    add(0, 1, 0, 12'h123, 8'h00, 1, 12'h0FF, 1, 0, 12'h0FF, 8'hA5, 0, 0, 1, 0, 8'h00);
    add(0, 1, 0, 12'h123, 8'h00, 1, 12'h0FF, 0, 0, 12'h0FF, 8'hA5, 0, 1, 1, 1, 8'hA5);
    add(0, 1, 0, 12'h123, 8'h00, 0, 12'h000, 0, 0, 12'h0FF, 8'hA5, 0, 0, 1, 0, 8'h00);
    add(0, 1, 0, 12'h123, 8'h00, 0, 12'h000, 1, 0, 12'h123, 8'h00, 0, 0, 1, 0, 8'h00);
    add(0, 1, 0, 12'h123, 8'h00, 0, 12'h000, 0, 0, 12'h123, 8'h00, 1, 0, 0, 1, 8'h5A);
    add(0, 0, 0, 12'h000, 8'h00, 0, 12'h000, 0, 0, 12'h123, 8'h00, 0, 0, 0, 0, 8'h00);
    // reset during ACCESS aborts; reissued read completes
    add(0, 1, 0, 12'h0FF, 8'h00, 0, 12'h000, 0, 0, 12'h123, 8'h00, 0, 0, 1, 0, 8'h00);
    add(1, 1, 0, 12'h0FF, 8'h00, 0, 12'h000, 1, 0, 12'h0FF, 8'h00, 0, 0, 1, 0, 8'h00);
    add(0, 1, 0, 12'h0FF, 8'h00, 0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 1, 0, 8'h00);
    add(0, 1, 0, 12'h0FF, 8'h00, 0, 12'h000, 1, 0, 12'h0FF, 8'h00, 0, 0, 1, 0, 8'h00);
    add(0, 1, 0, 12'h0FF, 8'h00, 0, 12'h000, 0, 0, 12'h0FF, 8'h00, 1, 0, 0, 1, 8'hA5);
    add(0, 0, 0, 12'h000, 8'h00, 0, 12'h000, 0, 0, 12'h0FF, 8'h00, 0, 0, 0, 0, 8'h00);

    rst = 1'b1;
    bus.cpuReq = 0; bus.cpuWe = 0; bus.cpuAddr = '0; bus.cpuWdata = '0;
    bus.videoReq = 0; bus.videoAddr = '0;
    bus2.cpuReq = 0; bus2.cpuWe = 0; bus2.cpuAddr = '0; bus2.cpuWdata = '0;
    bus2.videoReq = 0; bus2.videoAddr = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      rst           = vq[i].rst;
      bus.cpuReq    = vq[i].creq;
      bus.cpuWe     = vq[i].cwe;
      bus.cpuAddr   = vq[i].caddr;
      bus.cpuWdata  = vq[i].cwd;
      bus.videoReq  = vq[i].vreq;
      bus.videoAddr = vq[i].vaddr;
      @(negedge clk);
      chk("ramEn",    i, 32'(bus.ramEn),    32'(vq[i].en));
      chk("ramWe",    i, 32'(bus.ramWe),    32'(vq[i].we));
      chk("ramAddr",  i, 32'(bus.ramAddr),  32'(vq[i].addr));
      chk("ramWdata", i, 32'(bus.ramWdata), 32'(vq[i].wd));
      chk("cpuAck",   i, 32'(bus.cpuAck),   32'(vq[i].cack));
      chk("videoAck", i, 32'(bus.videoAck), 32'(vq[i].vack));
      chk("cpuWait",  i, 32'(bus.cpuWait),  32'(vq[i].cwait));
      if (vq[i].chkrd && vq[i].cack) chk("cpuRdata",   i, 32'(bus.cpuRdata),   32'(vq[i].rd));
      if (vq[i].chkrd && vq[i].vack) chk("videoRdata", i, 32'(bus.videoRdata), 32'(vq[i].rd));
      @(posedge clk);
      #1;
    end

    // STARVE_LIMIT=2, video always requesting, CPU pending: V,V,C,V
    rst = 1'b0;
    bus2.cpuReq = 1; bus2.cpuWe = 0; bus2.cpuAddr = 12'h010;
    bus2.videoReq = 1; bus2.videoAddr = 12'h020;
    for (int c = 0; c < 12; c++) begin
      if (c == 9) bus2.cpuReq = 0;
      @(negedge clk);
      chk("starve videoAck", c, 32'(bus2.videoAck), 32'(c == 2 || c == 5 || c == 11));
      chk("starve cpuAck",   c, 32'(bus2.cpuAck),   32'(c == 8));
      chk("starve cpuWait",  c, 32'(bus2.cpuWait),  32'(c < 8));
      if (c == 8) chk("starve cpuRdata",   c, 32'(bus2.cpuRdata),   32'h10);
      if (c == 2) chk("starve videoRdata", c, 32'(bus2.videoRdata), 32'h20);
      @(posedge clk);
      #1;
    end
    bus2.videoReq = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
